uart_bus_arbiter: RTL and testbench
===================================

Name: uart_bus_arbiter

Overview:
Two-master arbiter for the UART's 8-bit register bus (2-bit addr, data in/out, we, stb, ack). Master 0 is the RPi host bus; master 1 is an internal requester (status/probe logic). Grants one master at a time, forwards a single register access to the UART, and returns data and ack to the granted master. A timeout covers the UART's ack not being relied on today.

Parameters:
ADDR_W, 2, register address width
DATA_W, 8, data bus width
TIMEOUT, 255, cycles to wait for s_ack before forced completion; 0 = wait forever

Ports:
ref_clk  in  1  single clock for the block
reset_n  in  1  synchronous, active-low reset
m0_addr  in  ADDR_W  master 0 register address
m0_data_in  in  DATA_W  master 0 write data
m0_data_out  out  DATA_W  master 0 read data
m0_we  in  1  master 0 write enable
m0_stb  in  1  master 0 request
m0_ack  out  1  master 0 completion, 1-cycle pulse
m0_err  out  1  master 0 timeout flag, valid with m0_ack
m1_addr, m1_data_in, m1_data_out, m1_we, m1_stb, m1_ack, m1_err  same as m0 for master 1
s_addr  out  ADDR_W  to UART wb_addr
s_data_out  out  DATA_W  to UART wb_data_in
s_data_in  in  DATA_W  from UART wb_data_out
s_we  out  1  to UART wb_we
s_stb  out  1  to UART wb_stb
s_ack  in  1  from UART wb_ack
grant  out  2  one-hot current owner, for LEDs

Behaviour:
- Sync active-low reset: state IDLE, last_grant=1 (master 0 wins first tie), timeout counter 0; all outputs 0.
- All outputs registered.
- States: IDLE, BUSY0, BUSY1, DONE.
- IDLE: only m0_stb -> BUSY0; only m1_stb -> BUSY1; both -> the master not equal to last_grant; none -> stay.
- On entry to BUSYn (cycle t+1 after request at edge t): latch mn_addr/we/data_in into s_addr/s_we/s_data_out, s_stb=1, grant[n]=1, last_grant=n, counter cleared.
- BUSYn with s_ack=1: capture s_data_in into mn_data_out; mn_ack=1 and mn_err=0 for one cycle; s_stb=0 and grant=0 in the same cycle; go to DONE.
- BUSYn with counter reaching TIMEOUT (TIMEOUT!=0) and no s_ack: mn_data_out=8'hFF, mn_ack=1, mn_err=1; s_stb=0; go to DONE.
- s_ack and timeout in the same cycle: s_ack wins (err=0).
- Counter saturates; width $clog2(TIMEOUT+1), minimum 1.
- BUSYn with mn_stb dropped before ack (protocol violation): abort; s_stb=0, grant=0, no mn_ack; go to IDLE next cycle.
- DONE: one dead cycle; acks clear; go to IDLE. A master must drop stb the cycle after its ack. A stb still high in IDLE is a new request.
- Minimum access: request edge t, s_stb at t+1, s_ack sampled at t+1 earliest, m_ack at t+2, re-arbitration at t+4.
- s_ack in IDLE or DONE: ignored.
- mn_data_out holds its last value until the next completed read by that master.
- Writes also update mn_data_out with s_data_in (don't-care to masters).
- Reset asserted mid-transaction: the next edge forces the reset state. The access is dropped and no ack is issued.

Decomposition:
- Shared include uart_bus_defs.vh: ADDR_W/DATA_W defaults, state encodings (IDLE=0, BUSY0=1, BUSY1=2, DONE=3), TIMEOUT default, TIMEOUT_DATA=8'hFF.
- One natural sub-module, bus_timeout_counter: clear/enable/saturate and a "hit" output at TIMEOUT.
- Arbitration and muxing stay in the top.

Test Plan:
- Reset: hold reset_n=0 for 3 edges with both stb=1 -> all outputs 0, grant=00. Release -> first grant=01 (master 0).
- Single write: m0 addr=2'b01, data=8'h41, we=1, s_ack one cycle after s_stb -> s_addr=01, s_data_out=41, s_we=1; m0_ack pulse two cycles after request, m0_err=0, m1_ack stays 0.
- Round-robin: both stb held continuously, slave acks immediately -> grants alternate 01,10,01,10. Each master is acked once per two transactions.
- Timeout: TIMEOUT=4, m1 read, s_ack tied 0 -> s_stb high exactly 4 cycles; then m1_ack=1, m1_err=1, m1_data_out=8'hFF.
- Read return: m1 read addr=2'b10, slave returns 8'h5A with s_ack -> m1_data_out=5A. Later m0 read returning 8'h33 leaves m1_data_out=5A.
- Abort and stray ack: m0 drops stb in BUSY0 -> s_stb falls next cycle, no m0_ack. An s_ack pulse in IDLE produces no ack on either master.

Source files
------------

// File: rtl/uart_bus_arbiter_pkg.sv
// Shared definitions for the UART register-bus arbiter.
// Holds the default bus widths and timeout, the data returned to a master
// on a forced (timed-out) completion, the arbiter state encoding, and a
// helper that sizes the timeout counter.
package uart_bus_arbiter_pkg;

    localparam int         ADDR_W_DEFAULT  = 2;
    localparam int         DATA_W_DEFAULT  = 8;
    localparam int         TIMEOUT_DEFAULT = 255;
    localparam logic [7:0] TIMEOUT_DATA    = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    // Width needed to count up to the timeout value; never narrower than
    // one bit so a TIMEOUT of 0 (wait forever) still elaborates.
    function automatic int counterWidth(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_bus_arbiter_bus_timeout_counter.sv
// Saturating cycle counter that bounds how long the arbiter waits for the
// UART to acknowledge an access.
// Ports:
//   i_clk      clock
//   i_reset_n  synchronous active-low reset
//   i_clear    return the count to zero (held while no access is in flight)
//   i_enable   count one cycle of an in-flight access
//   o_hit      this cycle is the TIMEOUT-th cycle of the access (never set
//              when TIMEOUT is 0)
module bus_timeout_counter
    import uart_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_hit
);

    localparam int            CW        = counterWidth(TIMEOUT);
    localparam logic [CW-1:0] COUNT_MAX = CW'(TIMEOUT);
    // The count holds the number of cycles already spent in the access, so
    // the TIMEOUT-th cycle is the one where the count reads TIMEOUT-1.
    localparam logic [CW-1:0] HIT_AT    = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Count cycles of the current access, clearing between accesses and
    // stopping at the top so a wait-forever access cannot wrap.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != COUNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (TIMEOUT != 0) && i_enable && (r_count >= HIT_AT);

endmodule

// File: rtl/uart_bus_arbiter.sv
// Two-master arbiter in front of the UART's register bus.
// Master 0 is the host bus, master 1 an internal requester. One access at a
// time is forwarded to the UART; its read data, ack and timeout flag go back
// to the master that owns it. Ties alternate, master 0 winning the first.
// Ports:
//   i_ref_clk, i_reset_n          clock, synchronous active-low reset
//   i_mN_addr/data_in/we/stb      master N request
//   o_mN_data_out/ack/err         master N response (ack is a 1-cycle pulse,
//                                 err marks a timed-out access)
//   o_s_addr/data_out/we/stb      request to the UART
//   i_s_data_in/ack               response from the UART
//   o_grant                       one-hot current owner
// All outputs are registered.
module uart_bus_arbiter
    import uart_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              i_ref_clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data_in,
    output logic [DATA_W-1:0] o_m0_data_out,
    input  logic              i_m0_we,
    input  logic              i_m0_stb,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data_in,
    output logic [DATA_W-1:0] o_m1_data_out,
    input  logic              i_m1_we,
    input  logic              i_m1_stb,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_data_out,
    input  logic [DATA_W-1:0] i_s_data_in,
    output logic              o_s_we,
    output logic              o_s_stb,
    input  logic              i_s_ack,
    output logic [1:0]        o_grant
);

    arb_state_t        r_state,       w_next_state;
    logic              r_last_grant,  w_last_grant;
    logic [ADDR_W-1:0] r_s_addr,      w_s_addr;
    logic [DATA_W-1:0] r_s_data_out,  w_s_data_out;
    logic              r_s_we,        w_s_we;
    logic              r_s_stb,       w_s_stb;
    logic [1:0]        r_grant,       w_grant;
    logic [DATA_W-1:0] r_m0_data_out, w_m0_data_out;
    logic              r_m0_ack,      w_m0_ack;
    logic              r_m0_err,      w_m0_err;
    logic [DATA_W-1:0] r_m1_data_out, w_m1_data_out;
    logic              r_m1_ack,      w_m1_ack;
    logic              r_m1_err,      w_m1_err;

    logic w_busy;
    logic w_hit;
    logic w_pick0;
    logic w_pick1;

    assign w_busy = (r_state == ST_BUSY0) || (r_state == ST_BUSY1);

    // r_last_grant holds the index of the previous owner; on a tie the other
    // master wins, so resetting it to 1 hands master 0 the first tie.
    assign w_pick0 = i_m0_stb && (!i_m1_stb || r_last_grant);
    assign w_pick1 = i_m1_stb && (!i_m0_stb || !r_last_grant);

    bus_timeout_counter #(
        .TIMEOUT  (TIMEOUT)
    ) u_timeout (
        .i_clk    (i_ref_clk),
        .i_reset_n(i_reset_n),
        .i_clear  (!w_busy),
        .i_enable (w_busy),
        .o_hit    (w_hit)
    );

    // State and output registers. Every output leaves the block from a flop,
    // so the comb processes below only compute next values.
    always_ff @(posedge i_ref_clk) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= 1'b1;
            r_s_addr      <= '0;
            r_s_data_out  <= '0;
            r_s_we        <= 1'b0;
            r_s_stb       <= 1'b0;
            r_grant       <= 2'b00;
            r_m0_data_out <= '0;
            r_m0_ack      <= 1'b0;
            r_m0_err      <= 1'b0;
            r_m1_data_out <= '0;
            r_m1_ack      <= 1'b0;
            r_m1_err      <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_last_grant  <= w_last_grant;
            r_s_addr      <= w_s_addr;
            r_s_data_out  <= w_s_data_out;
            r_s_we        <= w_s_we;
            r_s_stb       <= w_s_stb;
            r_grant       <= w_grant;
            r_m0_data_out <= w_m0_data_out;
            r_m0_ack      <= w_m0_ack;
            r_m0_err      <= w_m0_err;
            r_m1_data_out <= w_m1_data_out;
            r_m1_ack      <= w_m1_ack;
            r_m1_err      <= w_m1_err;
        end
    end

    // Next state. A dropped strobe while busy abandons the access straight
    // back to IDLE; otherwise an ack or a timeout finishes it through DONE,
    // which gives the master a cycle to lower its strobe.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_pick0) begin
                    w_next_state = ST_BUSY0;
                end else if (w_pick1) begin
                    w_next_state = ST_BUSY1;
                end
            end
            ST_BUSY0: begin
                if (!i_m0_stb) begin
                    w_next_state = ST_IDLE;
                end else if (i_s_ack || w_hit) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_BUSY1: begin
                if (!i_m1_stb) begin
                    w_next_state = ST_IDLE;
                end else if (i_s_ack || w_hit) begin
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Next output values. Bus fields and read data hold by default; ack and
    // err default low so they pulse for exactly one cycle. An ack arriving on
    // the timeout cycle is honoured as a normal completion.
    always_comb begin
        w_last_grant  = r_last_grant;
        w_s_addr      = r_s_addr;
        w_s_data_out  = r_s_data_out;
        w_s_we        = r_s_we;
        w_s_stb       = r_s_stb;
        w_grant       = r_grant;
        w_m0_data_out = r_m0_data_out;
        w_m0_ack      = 1'b0;
        w_m0_err      = 1'b0;
        w_m1_data_out = r_m1_data_out;
        w_m1_ack      = 1'b0;
        w_m1_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick0) begin
                    w_s_addr     = i_m0_addr;
                    w_s_data_out = i_m0_data_in;
                    w_s_we       = i_m0_we;
                    w_s_stb      = 1'b1;
                    w_grant      = 2'b01;
                    w_last_grant = 1'b0;
                end else if (w_pick1) begin
                    w_s_addr     = i_m1_addr;
                    w_s_data_out = i_m1_data_in;
                    w_s_we       = i_m1_we;
                    w_s_stb      = 1'b1;
                    w_grant      = 2'b10;
                    w_last_grant = 1'b1;
                end
            end
            ST_BUSY0: begin
                if (!i_m0_stb) begin
                    w_s_stb = 1'b0;
                    w_grant = 2'b00;
                end else if (i_s_ack) begin
                    w_m0_data_out = i_s_data_in;
                    w_m0_ack      = 1'b1;
                    w_s_stb       = 1'b0;
                    w_grant       = 2'b00;
                end else if (w_hit) begin
                    w_m0_data_out = DATA_W'(TIMEOUT_DATA);
                    w_m0_ack      = 1'b1;
                    w_m0_err      = 1'b1;
                    w_s_stb       = 1'b0;
                    w_grant       = 2'b00;
                end
            end
            ST_BUSY1: begin
                if (!i_m1_stb) begin
                    w_s_stb = 1'b0;
                    w_grant = 2'b00;
                end else if (i_s_ack) begin
                    w_m1_data_out = i_s_data_in;
                    w_m1_ack      = 1'b1;
                    w_s_stb       = 1'b0;
                    w_grant       = 2'b00;
                end else if (w_hit) begin
                    w_m1_data_out = DATA_W'(TIMEOUT_DATA);
                    w_m1_ack      = 1'b1;
                    w_m1_err      = 1'b1;
                    w_s_stb       = 1'b0;
                    w_grant       = 2'b00;
                end
            end
            default: begin
            end
        endcase
    end

    assign o_s_addr      = r_s_addr;
    assign o_s_data_out  = r_s_data_out;
    assign o_s_we        = r_s_we;
    assign o_s_stb       = r_s_stb;
    assign o_grant       = r_grant;
    assign o_m0_data_out = r_m0_data_out;
    assign o_m0_ack      = r_m0_ack;
    assign o_m0_err      = r_m0_err;
    assign o_m1_data_out = r_m1_data_out;
    assign o_m1_ack      = r_m1_ack;
    assign o_m1_err      = r_m1_err;

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter built with a 4-cycle timeout.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_uart_bus_arbiter;

    logic       clk = 1'b0;
    logic       resetN;
    logic [1:0] m0Addr, m1Addr, sAddr;
    logic [7:0] m0DataIn, m1DataIn, m0DataOut, m1DataOut, sDataOut, sDataIn;
    logic       m0We, m1We, m0Stb, m1Stb, m0Ack, m1Ack, m0Err, m1Err;
    logic       sWe, sStb, sAck;
    logic [1:0] grant;

    int checks = 0;
    int errors = 0;

    uart_bus_arbiter #(
        .ADDR_W (2),
        .DATA_W (8),
        .TIMEOUT(4)
    ) dut (
        .i_ref_clk    (clk),
        .i_reset_n    (resetN),
        .i_m0_addr    (m0Addr),
        .i_m0_data_in (m0DataIn),
        .o_m0_data_out(m0DataOut),
        .i_m0_we      (m0We),
        .i_m0_stb     (m0Stb),
        .o_m0_ack     (m0Ack),
        .o_m0_err     (m0Err),
        .i_m1_addr    (m1Addr),
        .i_m1_data_in (m1DataIn),
        .o_m1_data_out(m1DataOut),
        .i_m1_we      (m1We),
        .i_m1_stb     (m1Stb),
        .o_m1_ack     (m1Ack),
        .o_m1_err     (m1Err),
        .o_s_addr     (sAddr),
        .o_s_data_out (sDataOut),
        .i_s_data_in  (sDataIn),
        .o_s_we       (sWe),
        .o_s_stb      (sStb),
        .i_s_ack      (sAck),
        .o_grant      (grant)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Advance n rising edges, landing just after the last one.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive both master request buses.
    task automatic applyStimulus(input logic s0, input logic w0, input logic [1:0] a0,
                                 input logic [7:0] d0, input logic s1, input logic w1,
                                 input logic [1:0] a1, input logic [7:0] d1);
        m0Stb = s0; m0We = w0; m0Addr = a0; m0DataIn = d0;
        m1Stb = s1; m1We = w1; m1Addr = a1; m1DataIn = d1;
    endtask

    // Drive the UART response.
    task automatic applySlave(input logic ack, input logic [7:0] data);
        sAck = ack;
        sDataIn = data;
    endtask

    // One comparison: count it, and report it if the value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Safety net in case the sequence below ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=stalled expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset held for 3 edges with both masters requesting.
        resetN = 1'b0;
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
        applySlave(1'b0, 8'h00);
        tick(3);
        checkOutput("rst_grant", grant, 2'b00);
        checkOutput("rst_s_stb", sStb, 1'b0);
        checkOutput("rst_s_addr", sAddr, 2'b00);
        checkOutput("rst_m0_ack", m0Ack, 1'b0);
        checkOutput("rst_m1_ack", m1Ack, 1'b0);
        checkOutput("rst_m0_data", m0DataOut, 8'h00);

        // Release: the tie goes to master 0, whose write is forwarded.
        resetN = 1'b1;
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h41, 1'b1, 1'b0, 2'b10, 8'h77);
        tick(1);
        checkOutput("first_grant", grant, 2'b01);
        checkOutput("wr_s_stb", sStb, 1'b1);
        checkOutput("wr_s_addr", sAddr, 2'b01);
        checkOutput("wr_s_data", sDataOut, 8'h41);
        checkOutput("wr_s_we", sWe, 1'b1);
        checkOutput("wr_m0_ack_early", m0Ack, 1'b0);

        // UART acks one cycle after s_stb.
        applySlave(1'b1, 8'h99);
        applyStimulus(1'b1, 1'b1, 2'b01, 8'h41, 1'b0, 1'b0, 2'b10, 8'h77);
        tick(1);
        checkOutput("wr_m0_ack", m0Ack, 1'b1);
        checkOutput("wr_m0_err", m0Err, 1'b0);
        checkOutput("wr_m1_ack", m1Ack, 1'b0);
        checkOutput("wr_s_stb_drop", sStb, 1'b0);
        checkOutput("wr_grant_drop", grant, 2'b00);

        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        applySlave(1'b0, 8'h00);
        tick(1);
        checkOutput("done_ack_clear", m0Ack, 1'b0);
        checkOutput("wr_m0_data", m0DataOut, 8'h99);
        tick(1);
        checkOutput("idle_grant", grant, 2'b00);

        // Round-robin: both strobes held, UART acks at once. Master 0 owned
        // last, so master 1 wins the first tie.
        applyStimulus(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b0, 2'b10, 8'h00);
        applySlave(1'b1, 8'h10);
        tick(1);
        checkOutput("rr_grant1", grant, 2'b10);
        tick(1);
        checkOutput("rr_m1_ack1", m1Ack, 1'b1);
        checkOutput("rr_m0_ack1", m0Ack, 1'b0);
        tick(2);
        checkOutput("rr_grant2", grant, 2'b01);
        tick(1);
        checkOutput("rr_m0_ack2", m0Ack, 1'b1);
        checkOutput("rr_m1_ack2", m1Ack, 1'b0);
        tick(2);
        checkOutput("rr_grant3", grant, 2'b10);
        tick(1);
        checkOutput("rr_m1_ack3", m1Ack, 1'b1);
        tick(2);
        checkOutput("rr_grant4", grant, 2'b01);
        tick(1);
        checkOutput("rr_m0_ack4", m0Ack, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        applySlave(1'b0, 8'h00);
        tick(2);

        // Master 1 read of address 2 returns 5A.
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b10, 8'h00);
        tick(1);
        checkOutput("rd1_grant", grant, 2'b10);
        checkOutput("rd1_s_addr", sAddr, 2'b10);
        checkOutput("rd1_s_we", sWe, 1'b0);
        applySlave(1'b1, 8'h5A);
        tick(1);
        checkOutput("rd1_m1_ack", m1Ack, 1'b1);
        checkOutput("rd1_m1_err", m1Err, 1'b0);
        checkOutput("rd1_m1_data", m1DataOut, 8'h5A);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        applySlave(1'b0, 8'h00);
        tick(1);
        checkOutput("rd1_ack_clear", m1Ack, 1'b0);

        // Master 0 read returns 33 and leaves master 1 data alone.
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("rd0_grant", grant, 2'b01);
        applySlave(1'b1, 8'h33);
        tick(1);
        checkOutput("rd0_m0_ack", m0Ack, 1'b1);
        checkOutput("rd0_m0_data", m0DataOut, 8'h33);
        checkOutput("rd0_m1_keep", m1DataOut, 8'h5A);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        applySlave(1'b0, 8'h00);
        tick(1);

        // Timeout: master 1 read, no ack. s_stb stays up exactly 4 cycles.
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b01, 8'h00);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checkOutput($sformatf("to_s_stb_%0d", i), sStb, 1'b1);
            checkOutput($sformatf("to_m1_ack_%0d", i), m1Ack, 1'b0);
        end
        tick(1);
        checkOutput("to_s_stb_drop", sStb, 1'b0);
        checkOutput("to_m1_ack", m1Ack, 1'b1);
        checkOutput("to_m1_err", m1Err, 1'b1);
        checkOutput("to_m1_data", m1DataOut, 8'hFF);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("to_ack_clear", m1Ack, 1'b0);
        checkOutput("to_err_clear", m1Err, 1'b0);

        // Ack on the timeout cycle: the ack wins, no error.
        applyStimulus(1'b1, 1'b0, 2'b10, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(4);
        checkOutput("tie_s_stb", sStb, 1'b1);
        applySlave(1'b1, 8'h66);
        tick(1);
        checkOutput("tie_m0_ack", m0Ack, 1'b1);
        checkOutput("tie_m0_err", m0Err, 1'b0);
        checkOutput("tie_m0_data", m0DataOut, 8'h66);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        applySlave(1'b0, 8'h00);
        tick(1);

        // Abort: master 0 drops its strobe while busy.
        applyStimulus(1'b1, 1'b1, 2'b11, 8'hC3, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("ab_s_stb", sStb, 1'b1);
        applyStimulus(1'b0, 1'b1, 2'b11, 8'hC3, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("ab_s_stb_drop", sStb, 1'b0);
        checkOutput("ab_grant", grant, 2'b00);
        checkOutput("ab_m0_ack", m0Ack, 1'b0);
        tick(1);
        checkOutput("ab_m0_ack_late", m0Ack, 1'b0);

        // Stray UART ack while idle is ignored.
        applySlave(1'b1, 8'hEE);
        tick(1);
        checkOutput("stray_m0_ack", m0Ack, 1'b0);
        checkOutput("stray_m1_ack", m1Ack, 1'b0);
        checkOutput("stray_m0_data", m0DataOut, 8'h66);
        checkOutput("stray_m1_data", m1DataOut, 8'hFF);
        applySlave(1'b0, 8'h00);
        tick(1);

        // Reset in the middle of an access drops it without an ack.
        applyStimulus(1'b1, 1'b1, 2'b11, 8'hAB, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("mr_s_stb", sStb, 1'b1);
        resetN = 1'b0;
        applySlave(1'b1, 8'h12);
        tick(1);
        checkOutput("mr_s_stb_drop", sStb, 1'b0);
        checkOutput("mr_m0_ack", m0Ack, 1'b0);
        checkOutput("mr_grant", grant, 2'b00);
        checkOutput("mr_m0_data", m0DataOut, 8'h00);
        checkOutput("mr_s_addr", sAddr, 2'b00);

        // After reset the first tie again goes to master 0.
        resetN = 1'b1;
        applySlave(1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 2'b00, 8'h00, 1'b1, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("mr_first_grant", grant, 2'b01);
        applyStimulus(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00);
        tick(1);
        checkOutput("mr_abort_ack", m0Ack, 1'b0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
